// File: rtl/seq_barrel_shifter_pkg.sv
// ============================================================================
// Module : shift_pkg
// Brief  : Op encodings and FSM state type for the sequential barrel shifter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_barrel_shifter_shift_stage.sv
// ============================================================================
// Module : shift_stage
// Brief  : One combinational shift/rotate stage; amount is a one-hot 2^k.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic [WIDTH-1:0] in_val,
    input  logic [CNT_W-1:0] amt,
    input  logic [1:0]       op,
    input  logic             en,
    output logic [WIDTH-1:0] out_val
);

    logic [CNT_W-1:0]   w_shamt;
    logic [2*WIDTH-1:0] w_rol;
    logic [2*WIDTH-1:0] w_ror;
    logic [WIDTH-1:0]   w_res;

    // Largest stage is WIDTH/2, which still fits in CNT_W bits.
    always_comb begin
        w_shamt = '0;
        for (int j = 0; j < CNT_W; j++) begin
            if (amt[j]) begin
                w_shamt = w_shamt | (CNT_W'(1) << j);
            end
        end
    end

    assign w_rol = {in_val, in_val} << w_shamt;
    assign w_ror = {in_val, in_val} >> w_shamt;

    always_comb begin
        case (op)
            OP_ROL:  w_res = w_rol[2*WIDTH-1:WIDTH];
            OP_SLL:  w_res = in_val << w_shamt;
            OP_ROR:  w_res = w_ror[WIDTH-1:0];
            default: w_res = in_val >> w_shamt;
        endcase
    end

    assign out_val = en ? w_res : in_val;

endmodule

`default_nettype wire

// File: rtl/seq_barrel_shifter.sv
// ============================================================================
// Module : seq_barrel_shifter
// Brief  : Multi-cycle shifter/rotator, one binary-weighted stage per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_barrel_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       op,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_data
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] w_stage_out;

    shift_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stage (
        .in_val  (work_q),
        .amt     (CNT_W'(1) << k_q),
        .op      (op_q),
        .en      (cnt_q[k_q]),
        .out_val (w_stage_out)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        k_d     = k_q;
        out_d   = out_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts directly so back-to-back ops see no idle bubble.
                if (start) begin
                    work_d  = in_data;
                    cnt_d   = cnt;
                    op_d    = op;
                    k_d     = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = w_stage_out;
                k_d    = k_q + CNT_W'(1);
                if (k_q == CNT_W'(CNT_W - 1)) begin
                    out_d   = w_stage_out;
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            k_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            k_q     <= k_d;
            out_q   <= out_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign ready    = ~busy;
    assign done     = (state_q == DONE);
    assign out_data = out_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_barrel_shifter.sv
// ============================================================================
// Module : tb_seq_barrel_shifter
// Brief  : Self-checking bench with a cycle-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_barrel_shifter;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op;
    logic             ready, busy, done;
    logic [WIDTH-1:0] out_data;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    seq_barrel_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .cnt      (cnt),
        .op       (op),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    // Reference: shift one bit position at a time, cnt times.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] x,
                                                   input logic [CNT_W-1:0] c,
                                                   input logic [1:0] o);
        logic [WIDTH-1:0] v = x;
        for (int i = 0; i < int'(c); i++) begin
            case (o)
                2'b00:   v = {v[WIDTH-2:0], v[WIDTH-1]};
                2'b01:   v = {v[WIDTH-2:0], 1'b0};
                2'b10:   v = {v[0], v[WIDTH-1:1]};
                default: v = {1'b0, v[WIDTH-1:1]};
            endcase
        end
        return v;
    endfunction

    // Model: an op occupies CNT_W busy cycles after accept, then one done cycle.
    int               m_left = 0;
    bit               m_done = 1'b0;
    logic [WIDTH-1:0] m_out = '0;
    logic [WIDTH-1:0] m_pending = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_out  = '0;
        end else begin
            bit accept;
            accept = start && (m_left == 0);
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_out  = m_pending;
                    m_done = 1'b1;
                end
            end
            if (accept) begin
                m_pending = ref_shift(in_data, cnt, op);
                m_left    = CNT_W;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_done",  32'(done),     32'(m_done));
            check("model_busy",  32'(busy),     32'(m_left > 0));
            check("model_ready", 32'(ready),    32'(m_left == 0));
            check("model_out",   32'(out_data), 32'(m_out));
        end
    end

    task automatic issue(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c, input logic [1:0] o);
        start   = 1'b1;
        in_data = d;
        cnt     = c;
        op      = o;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done is seen; bounded.
    task automatic wait_done(output int n, input bit flip);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            if (flip) begin
                in_data = WIDTH'($urandom);
                cnt     = CNT_W'($urandom);
                op      = 2'($urandom);
            end
            n++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic directed(input string name, input logic [WIDTH-1:0] d,
                            input logic [CNT_W-1:0] c, input logic [1:0] o,
                            input logic [WIDTH-1:0] exp, input bit flip);
        int n;
        issue(d, c, o);
        wait_done(n, flip);
        check({name, "_latency"}, 32'(n), 32'(CNT_W));
        check({name, "_data"}, 32'(out_data), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        int n;
        int done_seen;
        rst_n   = 1'b0;
        start   = 1'b0;
        in_data = '0;
        cnt     = '0;
        op      = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        check("reset_out",   32'(out_data), 32'h0);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_done",  32'(done), 32'd0);

        check("ref_ror", 32'(ref_shift(16'h1234, 4'd4, 2'b10)), 32'h4123);
        directed("ror4",   16'h1234, 4'd4,  2'b10, 16'h4123, 1'b0);
        directed("rol1",   16'h8001, 4'd1,  2'b00, 16'h0003, 1'b0);
        directed("srl15",  16'h8000, 4'd15, 2'b11, 16'h0001, 1'b0);
        directed("sll8",   16'hFFFF, 4'd8,  2'b01, 16'hFF00, 1'b0);
        directed("cnt0",   16'hBEEF, 4'd0,  2'b10, 16'hBEEF, 1'b0);
        directed("rol15",  16'h0001, 4'd15, 2'b00, 16'h8000, 1'b0);
        directed("flip",   16'h1234, 4'd4,  2'b10, 16'h4123, 1'b1);

        // Start while busy is ignored; start in DONE chains with no gap.
        issue(16'hA5C3, 4'd3, 2'b01);
        @(negedge clk);
        start = 1'b1; in_data = 16'hFFFF; cnt = 4'd7; op = 2'b11;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, 1'b0);
        check("ignore_latency", 32'(n + 2), 32'(CNT_W));
        check("ignore_data", 32'(out_data), 32'h2E18);
        issue(16'h00F0, 4'd4, 2'b00);
        wait_done(n, 1'b0);
        check("b2b_latency", 32'(n), 32'(CNT_W));
        check("b2b_data", 32'(out_data), 32'h0F00);
        @(negedge clk);

        // Reset in the middle of SHIFT abandons the op.
        issue(16'h1357, 4'd5, 2'b00);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out",   32'(out_data), 32'h0);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_busy",  32'(busy), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);
        directed("after_rst", 16'h0F0F, 4'd2, 2'b10, 16'hC3C3, 1'b0);

        // Random traffic with occasional reset; the model checks every cycle.
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            start   = ($urandom_range(0, 2) != 0);
            in_data = WIDTH'($urandom);
            cnt     = CNT_W'($urandom);
            op      = 2'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
